rv32_wb_arbiter: RTL
====================

# rv32_wb_arbiter

Writeback arbiter and scoreboard for the single write port of the RV32 register file. It merges two writeback sources onto that port: the in-order pipeline writeback stage, which has fixed priority and no backpressure, and a long-latency unit (mul/div/load), which uses a valid/ready handshake. It tracks destination registers with outstanding long-latency writes and raises an issue hazard on RAW/WAW conflicts. A starvation counter forces a pipeline stall so the long unit cannot be locked out indefinitely.

## Interface
- STARVE_LIMIT, default 4: consecutive refused long-unit cycles before stall_out asserts; minimum 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid_in  in  1  instruction present in the issue stage.
- issue_rs1_in / issue_rs2_in  in  5  source register indices.
- issue_rs1_read_in / issue_rs2_read_in  in  1  source is actually read.
- issue_rd_in  in  5  destination index.
- issue_rd_write_in  in  1  instruction writes rd.
- issue_long_in  in  1  instruction dispatches to the long unit; rd is written later by that unit.
- hazard_out  out  1  combinational; issue must hold this cycle.
- pipe_rd_in  in  5, pipe_rd_write_in  in  1, pipe_rd_value_in  in  32: pipeline writeback.
- long_valid_in  in  1, long_rd_in  in  5, long_value_in  in  32: long-unit result.
- long_ready_out  out  1  combinational; long result accepted when valid && ready.
- regs_rd_out  out  5, regs_rd_write_out  out  1, regs_rd_value_out  out  32: registered drive to the register-file write port.
- stall_out  out  1  registered; the pipeline freezes and its writeback stage holds its current write.

## Operation
- **Scoreboard** pend[31:0]; pend[0] is hard-wired to 0.
- **hazard_out** = issue_valid_in && ((rs1_read && pend[rs1]) || (rs2_read && pend[rs2]) || (rd_write && pend[rd])).
- **Set:** issue_valid_in && issue_long_in && issue_rd_write_in && rd≠0 && !hazard_out && !stall_out sets pend[rd].
- **Clear:** pend[r] clears on the edge where the register file commits the long write, i.e. when regs_rd_write_out=1 and the registered source tag is long.
  - Set and clear of the same index in the same cycle cannot occur, because the WAW term blocks the set. If it occurs anyway, set wins.
- **Arbitration:**
  - When stall_out=0, long_ready_out = !pipe_rd_write_in.
  - When stall_out=1, long_ready_out=1 and pipe_rd_write_in is ignored. The pipeline re-presents that write after the stall.
  - A pipeline write to rd=0 is dropped and the slot counts as free: long_ready_out=1.
  - A long write to rd=0 is accepted and discarded: no port write, no scoreboard effect.
- **Starvation counter** wait_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments each cycle long_valid_in && !long_ready_out.
  - Resets to 0 on long accept or when !long_valid_in.
  - stall_out is set on the edge where wait_cnt reaches STARVE_LIMIT with the long request still refused.
  - stall_out clears on the edge after the long accept.

## Timing
- **Reset values:** pend=0, wait_cnt=0, stall_out=0, regs_rd_write_out=0, regs_rd_out=0, regs_rd_value_out=0, source tag=pipe.
- **Write latency:** a write accepted in cycle N appears on regs_* in N+1 and is written to the register file at the end of N+1.
- **Hazard release:** for a long write accepted in N, hazard release is visible in N+2. An issue in N+2 reads the new value.
- **Reset mid-operation:** clears all pending bits and any write registered but not yet committed. The long unit is reset together with this block.
- **Starvation with STARVE_LIMIT=4:** for 4 refused cycles N..N+3, stall_out=1 from N+4, the long write is accepted in N+4, and stall_out=0 from N+5.

## Configuration
- **RV32_WB_ARB_SCOREBOARD_EN defined:** behaviour as above.
- **Not defined:**
  - The pend register and all set/clear logic are removed, and hazard_out is tied to 0.
  - This build is for cores where the long unit stalls the whole pipeline until completion.
  - Arbitration and starvation logic are unchanged.

## Test plan
- **Issue hold until commit:** issue long with rd=5, then issue an add reading x5 the next cycle. Required: hazard_out=1 until 2 cycles after the long accept; the add then reads the long value 0xDEADBEEF.
- **WAW:** a non-long writer with rd=5 while pend[5]=1. Required: hazard_out=1; no pend change.
- **Contention:** pipe write x3=0x11 and long valid x7=0x22 in the same cycle. Required: long_ready_out=0; regs write x3 next cycle; long accepted the following cycle.
- **Starvation, STARVE_LIMIT=4:** pipe writes every cycle with long valid. Required: stall_out rises after 4 refusals; long x9 written; stall_out falls one cycle later; the held pipe write completes afterwards.
- **x0:** long write to x0 and issue of long with rd=0. Required: regs_rd_write_out stays 0 for the long write to x0; pend stays 0; no hazard.
- **Mid-operation reset:** assert reset with pend[4]=1 and a write registered. Required: all outputs return to their reset values immediately; after release, hazard_out=0 for x4.

Source files
------------

// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter: merges pipeline and long-unit writebacks onto the RV32 register-file write port.
// Define RV32_WB_ARB_SCOREBOARD_EN to build the pending-register scoreboard and issue hazard.
module rv32_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid_in,
    input  logic [4:0]  issue_rs1_in,
    input  logic [4:0]  issue_rs2_in,
    input  logic        issue_rs1_read_in,
    input  logic        issue_rs2_read_in,
    input  logic [4:0]  issue_rd_in,
    input  logic        issue_rd_write_in,
    input  logic        issue_long_in,
    output logic        hazard_out,
    input  logic [4:0]  pipe_rd_in,
    input  logic        pipe_rd_write_in,
    input  logic [31:0] pipe_rd_value_in,
    input  logic        long_valid_in,
    input  logic [4:0]  long_rd_in,
    input  logic [31:0] long_value_in,
    output logic        long_ready_out,
    output logic [4:0]  regs_rd_out,
    output logic        regs_rd_write_out,
    output logic [31:0] regs_rd_value_out,
    output logic        stall_out
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    regs_rd_q, regs_rd_d;
    logic          regs_wr_q, regs_wr_d;
    logic [31:0]   regs_val_q, regs_val_d;
    logic          src_long_q, src_long_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d;
    logic          pipe_take, long_take;

    // Pipeline owns the port unless it writes x0 or the starvation stall is letting the long unit in
    always_comb begin
        pipe_take  = pipe_rd_write_in && (pipe_rd_in != 5'd0) && !stall_q;
        long_take  = long_valid_in && !pipe_take;
        regs_wr_d  = pipe_take || (long_take && (long_rd_in != 5'd0));
        regs_rd_d  = pipe_take ? pipe_rd_in : long_take ? long_rd_in : regs_rd_q;
        regs_val_d = pipe_take ? pipe_rd_value_in : long_take ? long_value_in : regs_val_q;
        src_long_d = long_take;
        wait_d     = (long_valid_in && pipe_take) ? wait_q + CW'(1) : '0;
        stall_d    = long_valid_in && pipe_take && (wait_q == CW'(STARVE_LIMIT - 1));
    end

    assign long_ready_out    = !pipe_take;
    assign regs_rd_out       = regs_rd_q;
    assign regs_rd_write_out = regs_wr_q;
    assign regs_rd_value_out = regs_val_q;
    assign stall_out         = stall_q;

    // Registered write port, source tag and starvation state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_rd_q  <= '0;
            regs_wr_q  <= 1'b0;
            regs_val_q <= '0;
            src_long_q <= 1'b0;
            wait_q     <= '0;
            stall_q    <= 1'b0;
        end else begin
            regs_rd_q  <= regs_rd_d;
            regs_wr_q  <= regs_wr_d;
            regs_val_q <= regs_val_d;
            src_long_q <= src_long_d;
            wait_q     <= wait_d;
            stall_q    <= stall_d;
        end
    end

`ifdef RV32_WB_ARB_SCOREBOARD_EN
    logic [31:0] pend_q, pend_d, set_mask, clr_mask;
    logic        issue_set;

    assign hazard_out = issue_valid_in && ((issue_rs1_read_in && pend_q[issue_rs1_in]) ||
                                           (issue_rs2_read_in && pend_q[issue_rs2_in]) ||
                                           (issue_rd_write_in && pend_q[issue_rd_in]));

    // Pending bit clears when the long write commits; a same-cycle set wins; x0 never pends
    always_comb begin
        issue_set = issue_valid_in && issue_long_in && issue_rd_write_in && (issue_rd_in != 5'd0) && !hazard_out && !stall_q;
        set_mask  = issue_set ? (32'd1 << issue_rd_in) : 32'd0;
        clr_mask  = (regs_wr_q && src_long_q) ? (32'd1 << regs_rd_q) : 32'd0;
        pend_d    = ((pend_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else pend_q <= pend_d;
    end
`else
    logic unused_issue;

    assign hazard_out   = 1'b0;
    assign unused_issue = ^{issue_valid_in, issue_rs1_in, issue_rs2_in, issue_rs1_read_in, issue_rs2_read_in,
                            issue_rd_in, issue_rd_write_in, issue_long_in, src_long_q};
`endif
endmodule
